mem_access_unit: RTL
====================

// Module: mem_access_unit
// PURPOSE
//  Load/store front end between the pipeline MEM stage and the data memory. Converts
//  RV32I byte/half/word accesses into aligned 32-bit word accesses: word-write
//  port, combinational word read, little-endian byte lanes.
//  Loads and word stores complete in one cycle.
//  SB/SH use a registered read-modify-write (RMW) sequence and stall the pipeline.
//  Flags misaligned or illegal accesses instead of touching memory.
// PARAMETERS
//  ADDR_W  32  width of addr/mem_A; word alignment forces mem_A[1:0]=2'b00
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous, active-high reset
//  req_valid    in   1       MEM stage holds a load/store this cycle
//  req_we       in   1       1=store, 0=load
//  funct3       in   3       000 B, 001 H, 010 W, 100 BU, 101 HU (loads only)
//  addr         in   ADDR_W  byte address from ALU
//  wdata        in   32      store data (rs2)
//  rdata        out  32      extended load result
//  rdata_valid  out  1       rdata is valid this cycle
//  stall        out  1       hold the pipeline (PC/IF/ID/EX/MEM registers)
//  access_fault out  1       misaligned or illegal funct3; no memory side effect
//  mem_we       out  1       data-memory write enable
//  mem_A        out  ADDR_W  word-aligned data-memory address
//  mem_WD       out  32      data-memory write data
//  mem_RD       in   32      data-memory combinational read data
// BEHAVIOUR
//  Reset
//   - State=IDLE.
//   - Outputs rdata=0, rdata_valid=0, stall=0, access_fault=0, mem_we=0,
//     mem_A=0, mem_WD=0.
//  Fault check (IDLE, req_valid=1)
//   - Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0.
//   - Illegal: funct3 in {011, 110, 111}; store with funct3 in {100, 101}.
//   - On fault: access_fault=1, mem_we=0, rdata_valid=0, stall=0.
//  States IDLE, RD, WR (others decode to IDLE)
//  IDLE, no request
//   - Outputs at reset values.
//   - mem_A = {addr[ADDR_W-1:2], 2'b00}, live.
//  IDLE, load
//   - Byte lane = addr[1:0]; half lane = addr[1].
//   - B/H sign-extend; BU/HU zero-extend; W passes through.
//   - rdata_valid=1, stall=0, 0-cycle latency. Stay in IDLE.
//  IDLE, store W
//   - mem_we=1, mem_WD=wdata; write commits at this edge.
//   - stall=0. Stay in IDLE.
//  IDLE, store B/H
//   - stall=1.
//   - Latch aligned address, addr[1:0], wdata, funct3 into hold registers.
//   - Next state RD.
//  RD
//   - mem_A from hold registers; live inputs ignored.
//   - merge_q <= mem_RD with the target lane(s) replaced by wdata[7:0] or wdata[15:0].
//   - mem_we=0, stall=1. Next state WR.
//  WR
//   - mem_A from hold registers; mem_we=1, mem_WD=merge_q.
//   - stall=0, so the pipeline advances at this edge. Next state IDLE.
//   - req_valid is ignored in WR: it is the same held instruction.
//  Timing
//   - SB/SH occupy 3 cycles with 2 stall cycles.
//   - The memory read path is never combined with the write path in one cycle.
//  Reset mid-operation
//   - rst in RD or WR: mem_we=0 in that cycle, next state IDLE.
//   - No partial write; hold registers cleared.
//  stall and access_fault are combinational from state and the request.
//   - The MEM stage must keep its request stable while stall=1.
// TESTING
//  1. mem[0x100]=0x8899AABB; LB addr 0x102 -> rdata=0xFFFFFF99, rdata_valid=1, stall=0.
//     Then LBU addr 0x102 -> rdata=0x00000099.
//  2. mem[0x100]=0x8899AABB; LH addr 0x102 -> rdata=0xFFFF8899.
//     LHU addr 0x100 -> rdata=0x0000AABB.
//  3. SW 0x12345678 to 0x200 -> mem_we=1 in the same cycle with mem_A=0x200.
//     stall never asserted. LW 0x200 -> 0x12345678.
//  4. mem[0x300]=0x11223344; SB wdata=0xFFFFFFAB addr 0x301 -> stall=1,1,0 across 3 cycles.
//     Single mem_we pulse in WR; mem[0x300]=0x1122AB44.
//  5. SH addr 0x103 -> access_fault=1, mem_we=0, stall=0.
//     LW addr 0x102 and funct3=011 behave the same way.
//  6. SH issued, rst=1 in the RD cycle -> no mem_we pulse, state IDLE, memory unchanged.
//     The next SB then completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store front end: turns RV32I byte/half/word accesses into aligned word
// accesses. Sub-word stores run a registered read-modify-write.
module mem_access_unit #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              rdata_valid,
    output logic              stall,
    output logic              access_fault,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_A,
    output logic [31:0]       mem_WD,
    input  logic [31:0]       mem_RD
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned BYTE_W = 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] hold_addr_q;
    logic [1:0]        hold_off_q;
    logic              hold_half_q;
    logic [HALF_W-1:0] hold_wdata_q;
    logic [WORD_W-1:0] merge_q;

    logic              capture;
    logic              merge_en;
    logic              fault;
    logic [BYTE_W-1:0] ld_byte;
    logic [HALF_W-1:0] ld_half;
    logic [WORD_W-1:0] ld_data;
    logic [WORD_W-1:0] merged;

    // Misalignment and illegal-encoding detection for the live request
    always_comb begin
        fault = 1'b0;
        case (funct3)
            F3_B:  fault = 1'b0;
            F3_H:  fault = addr[0];
            F3_W:  fault = (addr[1:0] != 2'b00);
            F3_BU: fault = req_we;
            F3_HU: fault = req_we | addr[0];
            default: fault = 1'b1;
        endcase
    end

    // Lane extraction and extension for loads
    always_comb begin
        ld_byte = BYTE_W'(mem_RD >> (5'(addr[1:0]) << 3));
        ld_half = addr[1] ? mem_RD[31:16] : mem_RD[15:0];
        ld_data = '0;
        case (funct3)
            F3_B:  ld_data = {{(WORD_W-BYTE_W){ld_byte[BYTE_W-1]}}, ld_byte};
            F3_H:  ld_data = {{(WORD_W-HALF_W){ld_half[HALF_W-1]}}, ld_half};
            F3_W:  ld_data = mem_RD;
            F3_BU: ld_data = {{(WORD_W-BYTE_W){1'b0}}, ld_byte};
            F3_HU: ld_data = {{(WORD_W-HALF_W){1'b0}}, ld_half};
            default: ld_data = '0;
        endcase
    end

    // Splice held store data into the word read back in RD
    always_comb begin
        merged = mem_RD;
        if (hold_half_q) begin
            if (hold_off_q[1]) merged[31:16] = hold_wdata_q;
            else               merged[15:0]  = hold_wdata_q;
        end else begin
            case (hold_off_q)
                2'd0:    merged[7:0]   = hold_wdata_q[7:0];
                2'd1:    merged[15:8]  = hold_wdata_q[7:0];
                2'd2:    merged[23:16] = hold_wdata_q[7:0];
                default: merged[31:24] = hold_wdata_q[7:0];
            endcase
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d      = state_q;
        rdata        = '0;
        rdata_valid  = 1'b0;
        stall        = 1'b0;
        access_fault = 1'b0;
        mem_we       = 1'b0;
        mem_A        = '0;
        mem_WD       = '0;
        capture      = 1'b0;
        merge_en     = 1'b0;

        if (rst) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    mem_A = {addr[ADDR_W-1:2], 2'b00};
                    if (req_valid) begin
                        if (fault) begin
                            access_fault = 1'b1;
                        end else if (!req_we) begin
                            rdata       = ld_data;
                            rdata_valid = 1'b1;
                        end else if (funct3 == F3_W) begin
                            mem_we = 1'b1;
                            mem_WD = wdata;
                        end else begin
                            stall   = 1'b1;
                            capture = 1'b1;
                            state_d = RD;
                        end
                    end
                end
                RD: begin
                    mem_A    = hold_addr_q;
                    stall    = 1'b1;
                    merge_en = 1'b1;
                    state_d  = WR;
                end
                WR: begin
                    mem_A   = hold_addr_q;
                    mem_we  = 1'b1;
                    mem_WD  = merge_q;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and hold registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            hold_addr_q  <= '0;
            hold_off_q   <= '0;
            hold_half_q  <= 1'b0;
            hold_wdata_q <= '0;
            merge_q      <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                hold_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                hold_off_q   <= addr[1:0];
                hold_half_q  <= funct3[0];
                hold_wdata_q <= wdata[15:0];
            end
            if (merge_en) begin
                merge_q <= merged;
            end
        end
    end

endmodule
